serial_burst_slave: RTL and testbench

Parametrised serial-bus slave with local block-RAM storage, the next generation of the team's bit-serial slave. It accepts single and burst read/write transactions over a 1-bit address/data serial interface and decodes a configurable base-address window, flagging out-of-range beats. It adds per-transaction completion/error status and read-data backpressure. It sits behind the bus arbiter/mux as one of several slaves sharing the serial lines.

---
 rtl/serial_burst_slave.sv | 188 ++++++++++++++++++
 tb/tb_serial_burst_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_burst_slave.sv
// Bit-serial burst slave with a windowed local RAM. A write completes ADN+N+3 cycles after the command, and so does a read with rdReady held; each extra beat adds N+1 cycles.
// Backpressure: ready drops during commit and fetch and while read data shifts out; rdReady=0 holds DataOut.
module serial_burst_slave #(
  parameter int N     = 8,
  parameter int ADN   = 12,
  parameter int DEPTH = 2048,
  parameter int BASE  = 0,
  parameter int BN    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       validIn,
  input  logic       wren,
  input  logic       BurstEn,
  input  logic       Address,
  input  logic       DataIn,
  input  logic       rdReady,
  output logic       ready,
  output logic       validOut,
  output logic       DataOut,
  output logic       done,
  output logic       err,
  output logic [2:0] state_out
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CMAX = (N > ADN) ? ((N > BN) ? N : BN) : ((ADN > BN) ? ADN : BN);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [ADN:0]  BASE_W   = (ADN+1)'(BASE);
  localparam logic [ADN:0]  DEPTH_W  = (ADN+1)'(DEPTH);
  localparam logic [CW-1:0] ADN_LAST = CW'(ADN - 1);
  localparam logic [CW-1:0] BN_LAST  = CW'(BN - 1);
  localparam logic [CW-1:0] N_LAST   = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR    = 3'd1,
    LEN     = 3'd2,
    WDATA   = 3'd3,
    WCOMMIT = 3'd4,
    RFETCH  = 3'd5,
    RSHIFT  = 3'd6
  } state_t;

  state_t         state;
  logic           isWr;
  logic           isBurst;
  logic           errFlag;
  logic [ADN-1:0] addr;
  logic [BN-1:0]  lenReg;
  logic [BN-1:0]  beat;
  logic [CW-1:0]  bitCnt;
  logic [N-1:0]   wdata;
  logic [N-1:0]   rdShift;
  logic [N-1:0]   mem [DEPTH];

  logic [ADN:0]   offset;
  logic           inRange;
  logic [AW-1:0]  memIdx;
  logic           accept;

  // An address below BASE wraps to at least 2^ADN+1 here, so one compare covers both bounds.
  assign offset  = {1'b0, addr} - BASE_W;
  assign inRange = offset < DEPTH_W;
  assign memIdx  = offset[AW-1:0];

  assign ready     = !reset && (state == IDLE || state == ADDR || state == LEN || state == WDATA);
  assign accept    = validIn && ready;
  assign validOut  = (state == RSHIFT);
  assign DataOut   = validOut && rdShift[N-1];
  assign state_out = state;

  // Storage and read shifter carry no reset so the RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (state == WCOMMIT && inRange) begin
      mem[memIdx] <= wdata;
    end
    if (state == RFETCH) begin
      rdShift <= inRange ? mem[memIdx] : '0;
    end else if (state == RSHIFT && rdReady) begin
      rdShift <= {rdShift[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      isWr    <= 1'b0;
      isBurst <= 1'b0;
      errFlag <= 1'b0;
      addr    <= '0;
      lenReg  <= '0;
      beat    <= '0;
      bitCnt  <= '0;
      wdata   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            isWr    <= wren;
            isBurst <= BurstEn;
            bitCnt  <= '0;
            beat    <= '0;
            lenReg  <= '0;
            errFlag <= 1'b0;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (accept) begin
            addr <= ADN'({addr, Address});
            if (bitCnt == ADN_LAST) begin
              bitCnt <= '0;
              if (isBurst)   state <= LEN;
              else if (isWr) state <= WDATA;
              else           state <= RFETCH;
            end else begin
              bitCnt <= bitCnt + CW'(1);
            end
          end
        end
        LEN: begin
          if (accept) begin
            lenReg <= BN'({lenReg, Address});
            if (bitCnt == BN_LAST) begin
              bitCnt <= '0;
              state  <= isWr ? WDATA : RFETCH;
            end else begin
              bitCnt <= bitCnt + CW'(1);
            end
          end
        end
        WDATA: begin
          if (accept) begin
            wdata <= {wdata[N-2:0], DataIn};
            if (bitCnt == N_LAST) begin
              bitCnt <= '0;
              state  <= WCOMMIT;
            end else begin
              bitCnt <= bitCnt + CW'(1);
            end
          end
        end
        WCOMMIT: begin
          if (!inRange) errFlag <= 1'b1;
          addr <= addr + ADN'(1);
          if (beat == lenReg) begin
            state <= IDLE;
            done  <= 1'b1;
            err   <= errFlag || !inRange;
          end else begin
            beat  <= beat + BN'(1);
            state <= WDATA;
          end
        end
        RFETCH: begin
          if (!inRange) errFlag <= 1'b1;
          state <= RSHIFT;
        end
        RSHIFT: begin
          if (rdReady) begin
            if (bitCnt == N_LAST) begin
              bitCnt <= '0;
              addr   <= addr + ADN'(1);
              if (beat == lenReg) begin
                state <= IDLE;
                done  <= 1'b1;
                err   <= errFlag;
              end else begin
                beat  <= beat + BN'(1);
                state <= RFETCH;
              end
            end else begin
              bitCnt <= bitCnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_burst_slave.sv
// Randomised scoreboard bench for serial_burst_slave: window 0x100..0xFFF, so both the lower edge and the 0xFFF->0x000 wrap are exercised.
module tb_serial_burst_slave;

  localparam int N     = 8;
  localparam int ADN   = 12;
  localparam int DEPTH = 3840;
  localparam int BASE  = 256;
  localparam int BN    = 3;
  localparam int ASPACE = 1 << ADN;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       validIn = 1'b0;
  logic       wren = 1'b0;
  logic       BurstEn = 1'b0;
  logic       Address = 1'b0;
  logic       DataIn = 1'b0;
  logic       rdReady = 1'b1;
  logic       ready, validOut, DataOut, done, err;
  logic [2:0] state_out;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  bit           expBits[$];
  bit           expErr[$];
  logic [N-1:0] model[int];
  logic [N-1:0] wd[8];

  serial_burst_slave #(.N(N), .ADN(ADN), .DEPTH(DEPTH), .BASE(BASE), .BN(BN)) dut (
    .clk(clk), .reset(reset), .validIn(validIn), .wren(wren), .BurstEn(BurstEn),
    .Address(Address), .DataIn(DataIn), .rdReady(rdReady), .ready(ready),
    .validOut(validOut), .DataOut(DataOut), .done(done), .err(err), .state_out(state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finishRun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  endtask

  task automatic timeoutFail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: no DUT response within bound (cycle %0d)", name, cyc);
    finishRun();
  endtask

  function automatic bit inWin(input int a);
    return (a >= BASE) && (a < BASE + DEPTH);
  endfunction

  function automatic logic [N-1:0] refRead(input int a);
    if (!inWin(a) || !model.exists(a)) return '0;
    return model[a];
  endfunction

  // Monitor: every read bit the master accepts, every done pulse, and DataOut stability under rdReady=0.
  logic prevHold = 1'b0;
  logic prevData = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (validOut) begin
        if (prevHold) check("dataout_hold", DataOut, prevData);
        if (rdReady) begin
          check("read_bit_expected", int'(expBits.size() > 0), 1);
          if (expBits.size() > 0) check("read_bit", DataOut, expBits.pop_front());
        end
      end
      if (done) begin
        check("done_expected", int'(expErr.size() > 0), 1);
        if (expErr.size() > 0) check("done_err", err, expErr.pop_front());
      end else begin
        check("err_without_done", err, 0);
      end
      prevHold <= validOut && !rdReady;
      prevData <= DataOut;
    end else begin
      prevHold <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = Address bit, 1 = DataIn bit, 2 = command cycle
  task automatic drive1(input int kind, input logic b, input bit gaps, output int accCyc);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    accCyc = 0;
    while (!acc) begin
      validIn = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (kind == 0) Address = b;
      else if (kind == 1) DataIn = b;
      @(negedge clk);
      acc = validIn && ready;
      accCyc = cyc;
      step();
      tries++;
      if (!acc && tries > 200) timeoutFail("bit_accept");
    end
    validIn = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_validOut"}, validOut, 0);
    check({tag, "_DataOut"}, DataOut, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_state"}, state_out, 0);
  endtask

  task automatic doTxn(input bit wr, input int a, input bit burst, input int len,
                       input bit gaps, input bit chkLat, input int abortBit);
    int c0, ct, pos, waited, beats, ba;
    bit errExp, seen;
    logic [N-1:0] w;
    beats = burst ? len + 1 : 1;
    errExp = 1'b0;
    if (abortBit < 0) begin
      for (int i = 0; i < beats; i++) begin
        ba = (a + i) % ASPACE;
        if (!inWin(ba)) errExp = 1'b1;
        if (wr) begin
          if (inWin(ba)) model[ba] = wd[i];
        end else begin
          w = refRead(ba);
          for (int k = N - 1; k >= 0; k--) expBits.push_back(w[k]);
        end
      end
      expErr.push_back(errExp);
    end

    wren = wr;
    BurstEn = burst;
    Address = 1'($urandom);
    drive1(2, 1'b0, gaps, c0);
    wren = 1'($urandom);
    BurstEn = 1'($urandom);
    for (int k = ADN - 1; k >= 0; k--) drive1(0, a[k], gaps, ct);
    if (burst) for (int k = BN - 1; k >= 0; k--) drive1(0, len[k], gaps, ct);
    pos = 0;
    if (wr) begin
      for (int i = 0; i < beats; i++) begin
        for (int k = N - 1; k >= 0; k--) begin
          drive1(1, wd[i][k], gaps, ct);
          pos++;
          if (abortBit >= 0 && pos == abortBit) begin
            #2 reset = 1'b1;
            #1 checkResetOutputs("midrst");
            @(posedge clk);
            @(posedge clk);
            @(negedge clk) reset = 1'b0;
            step();
            check("postrst_ready", ready, 1);
            check("postrst_state", state_out, 0);
            repeat (4) step();
            return;
          end
        end
      end
    end

    seen = 1'b0;
    waited = 0;
    while (!seen) begin
      if (!wr) rdReady = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      seen = done;
      ct = cyc;
      step();
      waited++;
      if (!seen && waited > 1000) timeoutFail("done_wait");
    end
    rdReady = 1'b1;
    if (chkLat) check("latency", ct - c0 + 1, ADN + N + 3 + (burst ? BN : 0) + len * (N + 1));
  endtask

  initial begin
    #500000;
    timeoutFail("watchdog");
  end

  initial begin
    bit wr, burst, gaps;
    int len, start;

    #12 checkResetOutputs("rst");
    @(negedge clk) reset = 1'b0;
    step();
    check("rel_ready", ready, 1);
    check("rel_state", state_out, 0);
    check("rel_validOut", validOut, 0);

    // Preload the regions that random traffic reads from.
    for (int a = 'h100; a <= 'h117; a++) begin
      wd[0] = N'($urandom);
      doTxn(1'b1, a, 1'b0, 0, 1'b0, 1'b0, -1);
    end
    for (int a = 'hFF0; a <= 'hFFF; a++) begin
      wd[0] = N'($urandom);
      doTxn(1'b1, a, 1'b0, 0, 1'b0, 1'b0, -1);
    end

    wd[0] = 8'hA5;
    doTxn(1'b1, 'h110, 1'b0, 0, 1'b0, 1'b1, -1);
    doTxn(1'b0, 'h110, 1'b0, 0, 1'b0, 1'b1, -1);

    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33; wd[3] = 8'h44;
    doTxn(1'b1, 'h120, 1'b1, 3, 1'b0, 1'b1, -1);
    doTxn(1'b0, 'h120, 1'b1, 3, 1'b0, 1'b1, -1);

    wd[0] = 8'h5A;
    doTxn(1'b1, 'h0FF, 1'b0, 0, 1'b0, 1'b1, -1);
    doTxn(1'b0, 'h100, 1'b1, 1, 1'b0, 1'b1, -1);
    doTxn(1'b0, 'h0FF, 1'b0, 0, 1'b0, 1'b1, -1);

    doTxn(1'b0, 'h104, 1'b1, 1, 1'b1, 1'b0, -1);

    wd[0] = 8'h3C;
    doTxn(1'b1, 'h130, 1'b0, 0, 1'b0, 1'b0, -1);
    wd[0] = 8'hC3;
    doTxn(1'b1, 'h130, 1'b0, 0, 1'b0, 1'b0, 4);
    doTxn(1'b0, 'h130, 1'b0, 0, 1'b0, 1'b1, -1);

    wd[0] = 8'h77; wd[1] = 8'h88;
    doTxn(1'b1, 'hFFF, 1'b1, 1, 1'b0, 1'b1, -1);
    doTxn(1'b0, 'hFFE, 1'b1, 2, 1'b0, 1'b1, -1);

    repeat (40) begin
      wr = 1'($urandom);
      burst = 1'($urandom);
      len = burst ? $urandom_range(0, 7) : 0;
      gaps = 1'($urandom);
      start = $urandom_range(0, 1) ? $urandom_range('h0FC, 'h10F) : $urandom_range('hFF8, 'hFFF);
      for (int i = 0; i < 8; i++) wd[i] = N'($urandom);
      doTxn(wr, start, burst, len, gaps, !gaps, -1);
    end

    repeat (3) step();
    check("bits_left", expBits.size(), 0);
    check("dones_left", expErr.size(), 0);
    finishRun();
  end

endmodule
